elvm_core: RTL and testbench

ELVM_CORE -- requirements
Module: elvm_core

---
 rtl/elvm_pkg.sv | 58 +++++
 rtl/elvm_dmem.sv | 25 ++
 rtl/elvm_core.sv | 189 ++++++++++++++++++
 tb/tb_elvm_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elvm_pkg.sv
// Shared definitions for the ELVM core: opcodes, register indices, FSM states
// and the condition decoder used by both compare and conditional-jump groups.
package elvm_pkg;

  localparam int NUM_REGS = 6;

  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_PUTC  = 5'd5;
  localparam logic [4:0] OP_GETC  = 5'd6;
  localparam logic [4:0] OP_EXIT  = 5'd7;
  localparam logic [4:0] OP_EQ    = 5'd8;
  localparam logic [4:0] OP_NE    = 5'd9;
  localparam logic [4:0] OP_LT    = 5'd10;
  localparam logic [4:0] OP_GT    = 5'd11;
  localparam logic [4:0] OP_LE    = 5'd12;
  localparam logic [4:0] OP_GE    = 5'd13;
  localparam logic [4:0] OP_JEQ   = 5'd14;
  localparam logic [4:0] OP_JNE   = 5'd15;
  localparam logic [4:0] OP_JLT   = 5'd16;
  localparam logic [4:0] OP_JGT   = 5'd17;
  localparam logic [4:0] OP_JLE   = 5'd18;
  localparam logic [4:0] OP_JGE   = 5'd19;
  localparam logic [4:0] OP_JMP   = 5'd20;

  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_D  = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_EXEC      = 3'd1,
    ST_LOAD_WB   = 3'd2,
    ST_PUTC_WAIT = 3'd3,
    ST_GETC_WAIT = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // off is the opcode offset from the group base (EQ or JEQ): EQ,NE,LT,GT,LE,GE.
  function automatic logic cond_true(input logic [4:0] off, input logic eq, input logic lt);
    case (off)
      5'd0:    return eq;
      5'd1:    return !eq;
      5'd2:    return lt;
      5'd3:    return !lt && !eq;
      5'd4:    return lt || eq;
      5'd5:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/elvm_dmem.sv
// Single-port data memory with synchronous, write-first read. Contents are not
// touched by reset.
module elvm_dmem #(
  parameter int WIDTH = 24,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/elvm_core.sv
// ELVM-style multi-cycle core: fetch from a synchronous ROM, execute, and
// optional wait states for memory load and the putc/getc byte streams.
module elvm_core
  import elvm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int AW    = 10,
  parameter int PW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PW-1:0]     imem_addr,
  input  logic [WIDTH+11:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              halted,
  output logic              illegal,
  output state_e            dbg_state
);

  localparam int IW = WIDTH + 12;

  // Streams use valid/ready: a byte moves on a rising edge where both are high;
  // the producer holds valid and data steady until then, ready never waits on valid.

  state_e state_q, state_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [2:0]       dst_q;
  logic [7:0]       out_data_q;
  logic             illegal_q, illegal_d;

  logic [4:0]       op;
  logic [2:0]       dst, src;
  logic             is_imm;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] dst_val, src_val, s_val, mem_rdata;

  assign op     = imem_data[IW-1 -: 5];
  assign dst    = imem_data[IW-6 -: 3];
  assign src    = imem_data[IW-9 -: 3];
  assign is_imm = imem_data[IW-12];
  assign imm    = imem_data[WIDTH-1:0];

  assign dst_val = (dst < 3'(NUM_REGS)) ? regs_q[dst] : '0;
  assign src_val = (src < 3'(NUM_REGS)) ? regs_q[src] : '0;
  assign s_val   = is_imm ? imm : src_val;

  logic alu_we, jmp_taken, op_bad, uses_dst, uses_src, reg_bad;
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    alu_we    = 1'b0;
    alu_res   = '0;
    jmp_taken = 1'b0;
    op_bad    = 1'b0;
    uses_dst  = 1'b0;
    uses_src  = 1'b0;
    case (op)
      OP_MOV: begin
        alu_we = 1'b1; alu_res = s_val; uses_dst = 1'b1; uses_src = !is_imm;
      end
      OP_ADD: begin
        alu_we = 1'b1; alu_res = dst_val + s_val; uses_dst = 1'b1; uses_src = !is_imm;
      end
      OP_SUB: begin
        alu_we = 1'b1; alu_res = dst_val - s_val; uses_dst = 1'b1; uses_src = !is_imm;
      end
      OP_LOAD, OP_STORE: begin
        uses_dst = 1'b1; uses_src = !is_imm;
      end
      OP_PUTC: uses_src = !is_imm;
      OP_GETC: uses_dst = 1'b1;
      OP_EXIT: ;
      OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE: begin
        alu_we   = 1'b1;
        alu_res  = WIDTH'(cond_true(op - OP_EQ, dst_val == s_val, dst_val < s_val));
        uses_dst = 1'b1;
        uses_src = !is_imm;
      end
      OP_JEQ, OP_JNE, OP_JLT, OP_JGT, OP_JLE, OP_JGE: begin
        jmp_taken = cond_true(op - OP_JEQ, dst_val == src_val, dst_val < src_val);
        uses_dst  = 1'b1;
        uses_src  = 1'b1;
      end
      OP_JMP:  jmp_taken = 1'b1;
      default: op_bad = 1'b1;
    endcase
  end

  assign reg_bad   = (uses_dst && dst >= 3'(NUM_REGS)) || (uses_src && src >= 3'(NUM_REGS));
  assign pc_d      = jmp_taken ? imm[PW-1:0] : pc_q + PW'(1);
  assign illegal_d = illegal_q | op_bad | reg_bad;

  // Single register write port shared by ALU results, load data and getc bytes.
  logic             wr_en;
  logic [2:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = dst;
    wr_data = alu_res;
    case (state_q)
      ST_EXEC:      wr_en = alu_we;
      ST_LOAD_WB: begin
        wr_en = 1'b1; wr_idx = dst_q; wr_data = mem_rdata;
      end
      ST_GETC_WAIT: begin
        wr_en = in_valid; wr_idx = dst_q; wr_data = WIDTH'(in_data);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      dst_q      <= '0;
      out_data_q <= '0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (state_q == ST_EXEC) begin
        pc_q      <= pc_d;
        dst_q     <= dst;
        illegal_q <= illegal_d;
        if (op == OP_PUTC) out_data_q <= s_val[7:0];
      end
      if (wr_en && wr_idx < 3'(NUM_REGS)) regs_q[wr_idx] <= wr_data;
    end
  end

  elvm_dmem #(.WIDTH(WIDTH), .AW(AW)) u_dmem (
    .clk     (clk),
    .we_i    (!rst && state_q == ST_EXEC && op == OP_STORE),
    .addr_i  (s_val[AW-1:0]),
    .wdata_i (dst_val),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LOAD: state_d = ST_LOAD_WB;
          OP_PUTC: state_d = ST_PUTC_WAIT;
          OP_GETC: state_d = ST_GETC_WAIT;
          OP_EXIT: state_d = ST_HALT;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_LOAD_WB:   state_d = ST_FETCH;
      ST_PUTC_WAIT: if (out_ready) state_d = ST_FETCH;
      ST_GETC_WAIT: if (in_valid)  state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_PUTC_WAIT: out_valid = 1'b1;
      ST_GETC_WAIT: in_ready  = 1'b1;
      ST_HALT:      halted    = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign out_data  = out_data_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_elvm_core.sv
// Directed bench for elvm_core: small ROM programs, putc bytes checked through
// an expected-byte queue, PC/state/flags checked at hand-counted cycles.
module tb_elvm_core;
  import elvm_pkg::*;

  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int PW    = 8;
  localparam int IW    = WIDTH + 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          out_valid, out_ready, in_valid, in_ready;
  logic [7:0]    out_data, in_data;
  logic          halted, illegal;
  state_e        dbg_state;

  elvm_core #(.WIDTH(WIDTH), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  logic [IW-1:0] rom [256];
  always @(posedge clk) imem_data <= rom[imem_addr];

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  logic [7:0] exp_q[$];

  function automatic logic [IW-1:0] enc(input logic [4:0] op, input logic [2:0] d,
                                        input logic [2:0] s, input logic im,
                                        input logic [7:0] imm);
    return {op, d, s, im, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tx_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL putc_unexpected got 0x%0h expected none", out_data);
      end else begin
        check("putc_byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(OP_EXIT, 3'd0, 3'd0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = halted;
    end
    check({name, "_halt"}, 32'(seen), 32'd1);
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_in_ready(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = in_ready;
    end
    check({name, "_in_ready"}, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    int   hold;
    logic bad_pc, saw_valid, saw_ready;

    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    clear_rom();

    // Reset state
    edges(3);
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_FETCH));

    // ALU: wrap-around add, SUB reg with itself, unsigned compare, putc immediate
    clear_rom();
    rom[0]  = enc(OP_MOV,  REG_A, 3'd0,  1'b1, 8'd250);
    rom[1]  = enc(OP_ADD,  REG_A, 3'd0,  1'b1, 8'd10);
    rom[2]  = enc(OP_PUTC, 3'd0,  REG_A, 1'b0, 8'd0);
    rom[3]  = enc(OP_MOV,  REG_B, 3'd0,  1'b1, 8'd9);
    rom[4]  = enc(OP_SUB,  REG_B, REG_B, 1'b0, 8'd0);
    rom[5]  = enc(OP_PUTC, 3'd0,  REG_B, 1'b0, 8'd0);
    rom[6]  = enc(OP_MOV,  REG_C, 3'd0,  1'b1, 8'd5);
    rom[7]  = enc(OP_LT,   REG_C, 3'd0,  1'b1, 8'd6);
    rom[8]  = enc(OP_PUTC, 3'd0,  REG_C, 1'b0, 8'd0);
    rom[9]  = enc(OP_PUTC, 3'd0,  3'd0,  1'b1, 8'h55);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'h55);
    do_reset();
    edges(4);
    check("alu_pc_after_add", 32'(imem_addr), 32'd2);
    check("alu_state_after_add", 32'(dbg_state), 32'(ST_FETCH));
    wait_halt("alu", 200);
    check("alu_pc_at_halt", 32'(imem_addr), 32'd11);
    check("alu_illegal", 32'(illegal), 32'd0);

    // PUTC back-pressure: ready low for 5 cycles, one transfer
    clear_rom();
    rom[0] = enc(OP_MOV,  REG_B, 3'd0,  1'b1, 8'h41);
    rom[1] = enc(OP_PUTC, 3'd0,  REG_B, 1'b0, 8'd0);
    exp_q.push_back(8'h41);
    out_ready = 1'b0;
    do_reset();
    tx_count = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
    check("putc_valid_seen", 32'(found), 32'd1);
    hold = (out_valid && out_data == 8'h41) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid && out_data == 8'h41) hold++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_halt("putc", 50);
    check("putc_hold_cycles", 32'(hold), 32'd5);
    check("putc_transfers", 32'(tx_count), 32'd1);

    // STORE with upper address bits set, LOAD from the aliased address
    clear_rom();
    rom[0] = enc(OP_MOV,   REG_A, 3'd0,  1'b1, 8'd7);
    rom[1] = enc(OP_STORE, REG_A, 3'd0,  1'b1, 8'd19);
    rom[2] = enc(OP_LOAD,  REG_C, 3'd0,  1'b1, 8'd3);
    rom[3] = enc(OP_PUTC,  3'd0,  REG_C, 1'b0, 8'd0);
    exp_q.push_back(8'd7);
    do_reset();
    edges(6);
    check("load_wb_state", 32'(dbg_state), 32'(ST_LOAD_WB));
    edges(1);
    check("load_done_state", 32'(dbg_state), 32'(ST_FETCH));
    check("load_done_pc", 32'(imem_addr), 32'd3);
    wait_halt("mem", 50);

    // JLT taken
    clear_rom();
    rom[0]  = enc(OP_MOV,  REG_A, 3'd0,  1'b1, 8'd3);
    rom[1]  = enc(OP_MOV,  REG_B, 3'd0,  1'b1, 8'd5);
    rom[2]  = enc(OP_JLT,  REG_A, REG_B, 1'b0, 8'd12);
    rom[3]  = enc(OP_PUTC, 3'd0,  3'd0,  1'b1, 8'hEE);
    rom[12] = enc(OP_PUTC, 3'd0,  3'd0,  1'b1, 8'h12);
    exp_q.push_back(8'h12);
    do_reset();
    edges(6);
    check("jlt_taken_pc", 32'(imem_addr), 32'd12);
    wait_halt("jlt_taken", 50);

    // JLT not taken
    clear_rom();
    rom[0]  = enc(OP_MOV,  REG_A, 3'd0,  1'b1, 8'd5);
    rom[1]  = enc(OP_MOV,  REG_B, 3'd0,  1'b1, 8'd3);
    rom[2]  = enc(OP_JLT,  REG_A, REG_B, 1'b0, 8'd12);
    rom[3]  = enc(OP_PUTC, 3'd0,  3'd0,  1'b1, 8'h03);
    rom[12] = enc(OP_PUTC, 3'd0,  3'd0,  1'b1, 8'hEE);
    exp_q.push_back(8'h03);
    do_reset();
    edges(6);
    check("jlt_not_taken_pc", 32'(imem_addr), 32'd3);
    wait_halt("jlt_not_taken", 50);

    // GETC, then reset asserted while waiting on a second GETC
    clear_rom();
    rom[0] = enc(OP_GETC, REG_D, 3'd0,  1'b0, 8'd0);
    rom[1] = enc(OP_PUTC, 3'd0,  REG_D, 1'b0, 8'd0);
    rom[2] = enc(OP_GETC, REG_A, 3'd0,  1'b0, 8'd0);
    exp_q.push_back(8'h7A);
    do_reset();
    wait_in_ready("getc_first");
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h7A;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_in_ready("getc_second");
    check("getc_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk); #1 in_valid = 1'b0;
    check("getc_rst_in_ready", 32'(in_ready), 32'd0);
    check("getc_rst_pc", 32'(imem_addr), 32'd0);
    check("getc_rst_state", 32'(dbg_state), 32'(ST_FETCH));
    clear_rom();
    rom[0] = enc(OP_PUTC, 3'd0, REG_D, 1'b0, 8'd0);
    rom[1] = enc(OP_PUTC, 3'd0, REG_A, 1'b0, 8'd0);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    @(posedge clk); #1 rst = 1'b0;
    wait_halt("getc_after_rst", 50);

    // HALT is absorbing while the streams toggle
    clear_rom();
    rom[0] = enc(OP_MOV,  REG_A, 3'd0,  1'b1, 8'h21);
    rom[1] = enc(OP_EXIT, 3'd0,  3'd0,  1'b0, 8'd0);
    rom[2] = enc(OP_PUTC, 3'd0,  REG_A, 1'b0, 8'd0);
    do_reset();
    wait_halt("exit", 20);
    bad_pc = 1'b0; saw_valid = 1'b0; saw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid  = ~in_valid;
      out_ready = ~out_ready;
      in_data   = 8'($urandom_range(0, 255));
      if (imem_addr != 8'd2) bad_pc = 1'b1;
      if (out_valid) saw_valid = 1'b1;
      if (in_ready) saw_ready = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("halt_pc_frozen_bad", 32'(bad_pc), 32'd0);
    check("halt_out_valid_seen", 32'(saw_valid), 32'd0);
    check("halt_in_ready_seen", 32'(saw_ready), 32'd0);
    check("halt_still_halted", 32'(halted), 32'd1);
    check("halt_state", 32'(dbg_state), 32'(ST_HALT));

    // Undefined opcode acts as NOP and sets illegal
    clear_rom();
    rom[0] = enc(5'd31,   3'd0, 3'd0, 1'b0, 8'd0);
    rom[1] = enc(OP_PUTC, 3'd0, 3'd0, 1'b1, 8'h31);
    exp_q.push_back(8'h31);
    do_reset();
    edges(1);
    check("illop_before", 32'(illegal), 32'd0);
    edges(1);
    check("illop_flag", 32'(illegal), 32'd1);
    check("illop_pc", 32'(imem_addr), 32'd1);
    wait_halt("illop", 50);
    check("illop_sticky", 32'(illegal), 32'd1);

    // Register index 6/7: write dropped, read as zero, illegal set
    clear_rom();
    rom[0] = enc(OP_MOV,  3'd6, 3'd0, 1'b1, 8'd5);
    rom[1] = enc(OP_PUTC, 3'd0, 3'd7, 1'b0, 8'd0);
    exp_q.push_back(8'h00);
    do_reset();
    edges(2);
    check("illreg_flag", 32'(illegal), 32'd1);
    wait_halt("illreg", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
